// File: rtl/booth_arith_pkg.sv
// Shared definitions for the Booth multiply/divide arithmetic blocks:
// sequencer state encoding and the iteration-counter width helper.
package booth_arith_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_ITER = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_LOAD = ST_LOAD,
    S_ITER = ST_ITER,
    S_FIX  = ST_FIX,
    S_DONE = ST_DONE
  } div_state_e;

  // Bits needed to hold an iteration count from 0 up to w inclusive.
  function automatic int ctr_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_sub_stage.sv
// Trial subtraction for one restoring-division step: t = a - b and
// ge = (a >= b), both operands treated as unsigned.
module div_sub_stage #(
  parameter int W = 16
) (
  input  logic [W:0] a,
  input  logic [W:0] b,
  output logic [W:0] t,
  output logic       ge
);

  logic [W+1:0] diff_s;

  // One extra bit on top so the borrow lands in the MSB.
  always_comb begin
    diff_s = {1'b0, a} - {1'b0, b};
    t      = diff_s[W:0];
    ge     = ~diff_s[W+1];
  end

endmodule

// File: rtl/booth_div_seq.sv
// Sequential signed divider: restoring division on operand magnitudes,
// then sign correction (quotient truncates toward zero, remainder follows N).
module booth_div_seq
  import booth_arith_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         Clock,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic [W-1:0] N,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q,
  output logic [W-1:0] R,
  output logic         Busy,
  output logic         Done,
  output logic         DivZero,
  output logic         Ovf
);

  localparam int             CW       = ctr_width(W);
  localparam logic [CW-1:0]  CTR_INIT = CW'(W);
  localparam logic [CW-1:0]  CTR_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]   ZERO_W   = {W{1'b0}};
  localparam logic [W-1:0]   ONE_W    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]   ONES_W   = {W{1'b1}};
  localparam logic [W-1:0]   MIN_NEG  = {1'b1, {(W-1){1'b0}}};

  div_state_e    state_r, state_nx_s;
  logic [W-1:0]  a_r, b_r, n_r;
  logic [W:0]    p_r;
  logic [CW-1:0] ctr_r;
  logic          sgn_q_r, sgn_rem_r, zero_r, ovf_r;
  logic [W-1:0]  q_r, r_r;
  logic          div_zero_r, ovf_out_r, busy_r, done_r;

  logic [W-1:0]  abs_n_s, abs_d_s, q_fix_s, r_fix_s;
  logic [W:0]    p_sh_s, t_s;
  logic          ge_s, take_s;

  assign p_sh_s = {p_r[W-1:0], a_r[W-1]};
  // A bit shifted out of P means the shifted value already exceeds any divisor.
  assign take_s = ge_s | p_r[W];

  div_sub_stage #(.W(W)) u_sub (
    .a  (p_sh_s),
    .b  ({1'b0, b_r}),
    .t  (t_s),
    .ge (ge_s)
  );

  // Operand magnitudes; |-2^(W-1)| is exact as an unsigned W-bit value.
  always_comb begin
    abs_n_s = N;
    abs_d_s = D;
    if (N[W-1]) abs_n_s = ~N + ONE_W;
    else        abs_n_s = N;
    if (D[W-1]) abs_d_s = ~D + ONE_W;
    else        abs_d_s = D;
  end

  // Signed results with divide-by-zero and overflow overrides.
  always_comb begin
    q_fix_s = a_r;
    r_fix_s = p_r[W-1:0];
    if (zero_r) begin
      q_fix_s = ONES_W;
      r_fix_s = n_r;
    end else if (ovf_r) begin
      q_fix_s = MIN_NEG;
      r_fix_s = ZERO_W;
    end else begin
      if (sgn_q_r)   q_fix_s = ~a_r + ONE_W;
      else           q_fix_s = a_r;
      if (sgn_rem_r) r_fix_s = ~p_r[W-1:0] + ONE_W;
      else           r_fix_s = p_r[W-1:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (Start) state_nx_s = S_LOAD;
        else       state_nx_s = S_IDLE;
      end
      S_LOAD: state_nx_s = S_ITER;
      S_ITER: begin
        if (ctr_r == CTR_ONE) state_nx_s = S_FIX;
        else                  state_nx_s = S_ITER;
      end
      S_FIX:   state_nx_s = S_DONE;
      S_DONE:  state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state_r <= S_IDLE;
    else          state_r <= state_nx_s;
  end

  // Operand latch and one-bit-per-cycle restoring iteration.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      a_r       <= ZERO_W;
      b_r       <= ZERO_W;
      n_r       <= ZERO_W;
      p_r       <= {1'b0, ZERO_W};
      ctr_r     <= {CW{1'b0}};
      sgn_q_r   <= 1'b0;
      sgn_rem_r <= 1'b0;
      zero_r    <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      case (state_r)
        S_LOAD: begin
          a_r       <= abs_n_s;
          b_r       <= abs_d_s;
          n_r       <= N;
          p_r       <= {1'b0, ZERO_W};
          ctr_r     <= CTR_INIT;
          sgn_q_r   <= N[W-1] ^ D[W-1];
          sgn_rem_r <= N[W-1];
          zero_r    <= (D == ZERO_W);
          ovf_r     <= (N == MIN_NEG) && (D == ONES_W);
        end
        S_ITER: begin
          a_r   <= {a_r[W-2:0], take_s};
          p_r   <= take_s ? t_s : p_sh_s;
          ctr_r <= ctr_r - CTR_ONE;
        end
        default: ctr_r <= ctr_r;
      endcase
    end
  end

  // Registered results, held until the next Fix; status follows next state.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      q_r        <= ZERO_W;
      r_r        <= ZERO_W;
      div_zero_r <= 1'b0;
      ovf_out_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      if (state_r == S_FIX) begin
        q_r        <= q_fix_s;
        r_r        <= r_fix_s;
        div_zero_r <= zero_r;
        ovf_out_r  <= ovf_r & ~zero_r;
      end
      busy_r <= (state_nx_s == S_LOAD) || (state_nx_s == S_ITER) ||
                (state_nx_s == S_FIX);
      done_r <= (state_nx_s == S_DONE);
    end
  end

  assign Q       = q_r;
  assign R       = r_r;
  assign Busy    = busy_r;
  assign Done    = done_r;
  assign DivZero = div_zero_r;
  assign Ovf     = ovf_out_r;

endmodule

// File: tb/tb_booth_div_seq.sv
// Scoreboard bench for booth_div_seq (W=8): expected results come from plain
// signed integer division and are checked by a Done-triggered monitor.
module tb_booth_div_seq;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
    int           s;
  } exp_t;

  logic         Clock = 1'b0;
  logic         Reset_n;
  logic         Start;
  logic [W-1:0] N, D, Q, R;
  logic         Busy, Done, DivZero, Ovf;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t sb[$];
  logic prev_done = 1'b0;
  logic prev_busy = 1'b0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  booth_div_seq #(.W(W)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .N(N), .D(D),
    .Q(Q), .R(R), .Busy(Busy), .Done(Done), .DivZero(DivZero), .Ovf(Ovf)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
    end
  endfunction

  // Reference: truncating signed division, remainder with the dividend's sign.
  function automatic exp_t model(input logic signed [W-1:0] n, input logic signed [W-1:0] d);
    exp_t e;
    int ni, di, qi, ri;
    ni = n;
    di = d;
    e.dz = 1'b0;
    e.ov = 1'b0;
    e.s  = 0;
    if (di == 0) begin
      qi = -1;
      ri = ni;
      e.dz = 1'b1;
    end else if (ni == -(2 ** (W - 1)) && di == -1) begin
      qi = -(2 ** (W - 1));
      ri = 0;
      e.ov = 1'b1;
    end else begin
      qi = ni / di;
      ri = ni % di;
    end
    e.q = qi[W-1:0];
    e.r = ri[W-1:0];
    return e;
  endfunction

  task automatic wait_idle();
    int k = 0;
    while ((Busy || Done) && k < 100) begin
      @(negedge Clock);
      k++;
    end
    if (k >= 100) check("idle_timeout", k, 0);
  endtask

  task automatic do_div(input logic signed [W-1:0] n, input logic signed [W-1:0] d);
    exp_t e;
    wait_idle();
    Start = 1'b1;
    N = n;
    D = d;
    @(negedge Clock);
    Start = 1'b0;
    check("busy_in_load", int'(Busy), 1);
    e = model(n, d);
    e.s = cyc;
    sb.push_back(e);
    @(negedge Clock);
    N = W'($urandom);
    D = W'($urandom);
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge Clock) begin
    exp_t e;
    if (Reset_n && Done) begin
      check("done_single_cycle", int'(prev_done), 0);
      check("done_expected", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("q", int'(Q), int'(e.q));
        check("r", int'(R), int'(e.r));
        check("divzero", int'(DivZero), int'(e.dz));
        check("ovf", int'(Ovf), int'(e.ov));
        // Start edge counted as edge 1; Done follows edge W+3.
        check("latency_edges", cyc - e.s + 1, W + 3);
        check("busy_through_fix", int'(prev_busy), 1);
        check("busy_low_in_done", int'(Busy), 0);
        last_q <= e.q;
        last_r <= e.r;
      end
    end
    prev_done <= Done;
    prev_busy <= Busy;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dn[10] = '{100, -100, 100, -100, 7, -128, -128, 127, 5, 6};
    int dd[10] = '{7, 7, -7, -7, -8, -1, 1, 127, 0, 3};
    exp_t e;
    int k;

    Reset_n = 1'b0;
    Start = 1'b0;
    N = '0;
    D = '0;
    #12;
    check("rst_q", int'(Q), 0);
    check("rst_r", int'(R), 0);
    check("rst_busy", int'(Busy), 0);
    check("rst_done", int'(Done), 0);
    check("rst_divzero", int'(DivZero), 0);
    check("rst_ovf", int'(Ovf), 0);
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);

    for (int i = 0; i < 10; i++) do_div(W'(dn[i]), W'(dd[i]));

    // A Start pulse mid-iteration must not queue or disturb the division.
    do_div(8'sd100, 8'sd7);
    repeat (3) @(negedge Clock);
    Start = 1'b1;
    N = 8'hFD;
    D = 8'h02;
    @(negedge Clock);
    Start = 1'b0;
    wait_idle();

    // Start held high: one division every W+4 cycles.
    @(negedge Clock);
    Start = 1'b1;
    N = 8'hB3;
    D = 8'h09;
    @(negedge Clock);
    e = model(8'shB3, 8'sh09);
    e.s = cyc;
    sb.push_back(e);
    repeat (W + 4) @(negedge Clock);
    e.s = cyc;
    sb.push_back(e);
    Start = 1'b0;
    wait_idle();
    @(negedge Clock);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      logic signed [W-1:0] rn, rd;
      rn = W'($urandom);
      rd = W'($urandom);
      case ($urandom_range(0, 5))
        0: rd = 8'sd0;
        1: rd = -8'sd1;
        2: rn = -8'sd128;
        3: rd = W'($urandom_range(1, 3));
        default: ;
      endcase
      do_div(rn, rd);
    end
    wait_idle();
    @(negedge Clock);

    // Results persist through Idle.
    repeat (4) @(negedge Clock);
    check("hold_q", int'(Q), int'(last_q));
    check("hold_r", int'(R), int'(last_r));

    // Asynchronous reset in the middle of Iter abandons the division.
    do_div(8'sd33, 8'sd4);
    repeat (3) @(negedge Clock);
    #2;
    Reset_n = 1'b0;
    #1;
    check("arst_q", int'(Q), 0);
    check("arst_r", int'(R), 0);
    check("arst_busy", int'(Busy), 0);
    check("arst_done", int'(Done), 0);
    check("arst_divzero", int'(DivZero), 0);
    check("arst_ovf", int'(Ovf), 0);
    sb.delete();
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
    do_div(8'sd50, 8'sd6);

    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge Clock);
      k++;
    end
    check("scoreboard_drained", sb.size(), 0);
    repeat (W + 4) @(negedge Clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_div_seq.md
Name: booth_div_seq

Overview:
- Sequential signed W-bit integer divider; the inverse companion of the team's Booth multiplier.
- Same Start-driven, multi-cycle style as the multiplier.
- Radix-2 restoring division on operand magnitudes, followed by sign correction.
- Quotient truncates toward zero; the remainder takes the dividend's sign.
- Sits beside the multiplier in the arithmetic datapath and is driven by the same controller-level Start pulse.

Parameters:
- W, 16, operand and result bit width (W >= 4).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset_n  in  1  reset, asynchronous, active-low.
- Start  in  1  begin a division; sampled only in Idle.
- N  in  W  signed dividend; sampled on the edge that leaves Load.
- D  in  W  signed divisor; sampled on the same edge as N.
- Q  out  W  signed quotient, registered.
- R  out  W  signed remainder, registered.
- Busy  out  1  high in Load, Iter and Fix.
- Done  out  1  one-cycle pulse; Q, R and flags are valid from this cycle.
- DivZero  out  1  D was 0 for the last completed division.
- Ovf  out  1  N = -2^(W-1) and D = -1 for the last completed division.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (Reset_n low, any time, including mid-operation):
  - State goes to Idle immediately.
  - Q, R, DivZero, Ovf, Busy and Done all read 0.
  - Internal registers are cleared; no partial result survives.
- States: Idle, Load, Iter, Fix, Done.
- Idle: Start=1 -> Load; otherwise stay in Idle.
- Load:
  - Latch |N| into the W-bit dividend/quotient shift register A and |D| into the W-bit divisor register B.
  - Clear the (W+1)-bit partial remainder P.
  - Latch sgnQ = N[W-1]^D[W-1], sgnR = N[W-1], zero = (D==0), ovf = (N==-2^(W-1) && D==-1).
  - Set CTR = W. Go to Iter.
  - Magnitudes are unsigned W-bit, so |-2^(W-1)| = 2^(W-1) is exact.
- Iter, one quotient bit per cycle:
  - Shift {P,A} left by 1 and form T = P_shifted - {0,B}.
  - If T >= 0: P = T and A[0] = 1; otherwise P is kept (restore) and A[0] = 0.
  - CTR decrements every Iter cycle; when CTR reaches 1 on this cycle, go to Fix.
- Fix:
  - Q = sgnQ ? -A : A, truncated to W bits.
  - R = sgnR ? -P[W-1:0] : P[W-1:0].
  - zero overrides: Q = all ones (-1), R = N as latched. DivZero = 1, Ovf = 0.
  - ovf case: Q = -2^(W-1) (wraps naturally), R = 0, Ovf = 1.
  - Go to Done.
- Done: Done=1 for exactly one cycle, then Idle unconditionally.
- Latency: Done is high in the cycle after the (W+3)-th rising edge counted from the edge that sampled Start. The edge sequence is Load, W x Iter, Fix.
- Divide-by-zero and overflow take the full latency; there is no early exit.
- Q, R, DivZero and Ovf hold their values after Done until the next Fix. They are not zeroed in Idle.
- Start while Busy or in Done is ignored and is not queued.
- Start held high continuously re-triggers one division per W+4 cycles.
- N and D may change after the Load edge without affecting the result.

Decomposition:
- Shared package booth_arith_pkg:
  - State encoding localparams (3-bit: Idle=0, Load=1, Iter=2, Fix=3, Done=4).
  - Width helper for CTR: $clog2(W+1).
- One sub-module: div_sub_stage.
  - Combinational (W+1)-bit subtract producing T and a ge flag.
  - Instantiated once; all sequencing stays in booth_div_seq.

Test Plan (W=8):
- Reset_n low, then high -> Q=0, R=0, Busy=0, Done=0, DivZero=0, Ovf=0. Start=1 with N=100, D=7 -> Done pulses exactly 11 edges after the Start edge; Q=14, R=2.
- Sign combinations -> each result must show Ovf=0:
  - N=-100, D=7 -> Q=-14, R=-2.
  - N=100, D=-7 -> Q=-14, R=2.
  - N=-100, D=-7 -> Q=14, R=-2.
  - N=7, D=-8 -> Q=0, R=7.
- Edge values:
  - N=-128, D=-1 -> Q=-128 (8'h80), R=0, Ovf=1.
  - N=-128, D=1 -> Q=-128, R=0, Ovf=0.
  - N=127, D=127 -> Q=1, R=0.
- N=5, D=0 -> Q=8'hFF, R=5, DivZero=1, still 11-edge latency. A following N=6, D=3 -> Q=2, R=0, DivZero=0.
- Start pulsed again during Iter with different N, D -> ignored; the first result completes unchanged. Busy high from the Load cycle through Fix.
- Reset_n asserted asynchronously mid-Iter (between clock edges) -> all outputs are 0 before the next edge, state is Idle. A subsequent N=50, D=6 completes with Q=8, R=2.
